cdr_link_ctrl: RTL and testbench
================================

# cdr_link_ctrl

Link controller for the 4x-oversampling clock/data recovery block (40 MHz `clk`, 10 Mb/s line). It supervises the recovered strobe and data:
- Holds the recovery block in reset when resynchronisation is needed.
- Qualifies lock from strobe spacing.
- Hunts for a sync byte, then delivers fixed-length frames as bytes over a valid/ready handshake.
- Forces a resync on strobe loss or spacing violations.

It sits between the recovery block and the frame consumer in the power-unit receive path.

## Interface
Parameters:
- `RST_CYC`, 8: cycles `cdr_rstn` is held low per resync.
- `LOCK_CNT`, 16: consecutive in-range strobe intervals required for lock.
- `TIMEOUT`, 400: cycles without a strobe that declare loss.
- `MIN_GAP` / `MAX_GAP`, 3 / 5: legal strobe interval, in `clk` cycles, inclusive.
- `SYNC_WORD`, 8'hA5: frame delimiter.
- `FRAME_LEN`, 4: payload bytes per frame (1..255).

Ports:
- `clk` in 1: 40 MHz clock.
- `rstn` in 1: asynchronous, active-low reset.
- `rcv_clk` in 1: recovered bit strobe, one `clk` wide.
- `rcv_data` in 1: recovered bit, valid with `rcv_clk`.
- `cdr_rstn` out 1: active-low reset to the recovery block.
- `locked` out 1: high in HUNT and DATA.
- `frame_start` out 1: one-cycle pulse on sync match.
- `byte_data` out 8: payload byte, MSB received first.
- `byte_valid` out 1: byte available.
- `byte_ready` in 1: consumer accepts.
- `ovf_clr` in 1: clears `overflow`.
- `overflow` out 1: sticky, a byte was dropped.
- `resync_cnt` out 8: saturating count of resyncs.

## Operation
- `rcv_clk` and `rcv_data` are registered once on input (`stb_r`, `bit_r`). All logic uses the registered copies.
- Gap counter: cleared to 0 on `stb_r`, otherwise increments, saturating at `TIMEOUT`. The interval at a strobe is gap+1. The first strobe after entering ACQUIRE is not checked.
- FSM states: RESYNC, ACQUIRE, HUNT, DATA.
  - RESYNC: `cdr_rstn`=0 for `RST_CYC` cycles, then go to ACQUIRE with the good-interval count cleared.
  - ACQUIRE:
    - An in-range interval increments the good count.
    - An out-of-range interval clears it to 0.
    - When the good count reaches `LOCK_CNT`, go to HUNT.
  - HUNT: shift `bit_r` into an 8-bit register on each strobe, MSB first. When the register equals `SYNC_WORD`, pulse `frame_start`, clear the bit and byte counters, and go to DATA.
  - DATA: assemble 8 bits into a byte and present it. After `FRAME_LEN` bytes, return to HUNT with the shift register cleared.
- Loss conditions, in ACQUIRE, HUNT or DATA:
  - Gap reaching `TIMEOUT` goes to RESYNC.
  - In HUNT or DATA only, an out-of-range interval also goes to RESYNC.
  - Every entry to RESYNC increments `resync_cnt` (saturates at 255). Entry from reset does not count.
  - On entry to RESYNC, partial bits are discarded.
- Output holding register:
  - A completed byte loads `byte_data` and sets `byte_valid`.
  - `byte_valid` clears on `byte_valid && byte_ready`.
  - If a byte completes while `byte_valid && !byte_ready`, the new byte is dropped, the held byte is kept, and `overflow` is set.
  - If a byte completes in the same cycle as acceptance, the new byte loads and `byte_valid` stays high.
  - A byte pending at resync stays valid until accepted.
- `ovf_clr` clears `overflow`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM is in RESYNC with the hold counter at 0.
  - `cdr_rstn`=0, `locked`=0, `frame_start`=0, `byte_valid`=0, `byte_data`=0, `overflow`=0, `resync_cnt`=0.
- `cdr_rstn` is registered. It goes high on the cycle ACQUIRE is entered, `RST_CYC` cycles after RESYNC entry.
- Latencies, counted from the `rcv_clk` high cycle that carries the completing bit:
  - `frame_start` pulses 2 cycles later.
  - `byte_valid` rises 2 cycles later.
- `locked` is registered and follows the state with no extra cycle.
- Timeout fires on the cycle the gap counter equals `TIMEOUT`. The state is RESYNC on the next cycle.
- If a strobe coincides with the timeout cycle, the strobe wins and the gap is evaluated as the interval.
- An `rstn` assertion mid-frame clears everything asynchronously, including a pending byte.

## Structure
- Shared package `cdr_pkg`:
  - FSM state enum (RESYNC/ACQUIRE/HUNT/DATA).
  - Default `SYNC_WORD`, `MIN_GAP`, `MAX_GAP`, `TIMEOUT`.
  - Width constants: byte = 8, gap counter width = clog2(`TIMEOUT`+1).
- One sub-module is natural: `cdr_gap_mon`. It contains the gap counter plus the in-range, out-of-range and timeout flags, and takes `stb_r` and `first` as inputs.
- The FSM, deserializer and output register stay in the top module.

## Test plan
- Ideal 4-cycle strobes after reset: `cdr_rstn` rises at cycle 8. `locked` rises after the 16th checked interval, which is the 17th strobe.
- Locked stream with bits A5 followed by 11 22 33 44:
  - `frame_start` pulses once.
  - Bytes 11, 22, 33, 44 are delivered in order with `byte_ready`=1.
  - The FSM then returns to HUNT.
- Strobes stop for 400 cycles in DATA: RESYNC entered, `cdr_rstn` low for 8 cycles, `resync_cnt`=1, `locked`=0.
- One 6-cycle interval in HUNT: immediate RESYNC. The same 6-cycle interval in ACQUIRE after 10 good intervals: good count resets to 0 and `locked` needs 16 further intervals.
- `byte_ready`=0 through a 4-byte frame: first byte 11 held, `overflow`=1. `ovf_clr` pulse clears it, and `byte_data` stays 11 until accepted.
- `rstn` asserted mid-byte with `byte_valid`=1: all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and defaults for the CDR link controller.
// No ports: state encoding, default line constants, widths.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_HUNT    = 2'd2,
    ST_DATA    = 2'd3
  } cdr_state_e;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam int MIN_GAP_DEF = 3;
  localparam int MAX_GAP_DEF = 5;
  localparam int TIMEOUT_DEF = 400;

  localparam int BYTE_W = 8;
  localparam int GAP_W  = $clog2(TIMEOUT_DEF + 1);

  function automatic int gap_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/cdr_gap_mon.sv
// Strobe spacing monitor: gap counter, interval range and timeout flags.
// In: clk, rstn, clr, stb_r, first. Out: in_rng, out_rng, tmo.
module cdr_gap_mon
  import cdr_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int MAX_GAP = MAX_GAP_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic stb_r,
  input  logic first,
  output logic in_rng,
  output logic out_rng,
  output logic tmo
);

  localparam int GW = gap_width(TIMEOUT);

  logic [GW-1:0] gap;
  logic [GW:0]   ivl;
  logic          chk;
  logic          ok;
  logic          sat;

  assign ivl = {1'b0, gap} + (GW+1)'(1);
  assign sat = gap == GW'(TIMEOUT);
  assign chk = stb_r && !first;

  assign ok = (ivl >= (GW+1)'(MIN_GAP)) &&
              (ivl <= (GW+1)'(MAX_GAP));

  assign in_rng  = chk && ok;
  assign out_rng = chk && !ok;

  // A strobe on the saturation cycle is judged
  // as an interval, not as a loss.
  assign tmo = sat && !stb_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap <= '0;
    end else if (clr || stb_r) begin
      gap <= '0;
    end else if (!sat) begin
      gap <= gap + GW'(1);
    end
  end

endmodule

// File: rtl/cdr_link_ctrl.sv
// CDR link controller: resync, lock, sync hunt, framed byte output.
// Ports: clk/rstn, rcv_clk/rcv_data in, cdr_rstn/locked/status out, byte handshake.
module cdr_link_ctrl
  import cdr_pkg::*;
#(
  parameter int         RST_CYC   = 8,
  parameter int         LOCK_CNT  = 16,
  parameter int         TIMEOUT   = TIMEOUT_DEF,
  parameter int         MIN_GAP   = MIN_GAP_DEF,
  parameter int         MAX_GAP   = MAX_GAP_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int         FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rcv_clk,
  input  logic              rcv_data,
  output logic              cdr_rstn,
  output logic              locked,
  output logic              frame_start,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  input  logic              ovf_clr,
  output logic              overflow,
  output logic [7:0]        resync_cnt
);

  localparam logic [1:0] RESYNC  = ST_RESYNC;
  localparam logic [1:0] ACQUIRE = ST_ACQUIRE;
  localparam logic [1:0] HUNT    = ST_HUNT;
  localparam logic [1:0] DATA    = ST_DATA;

  localparam int HOLD_W = $clog2(RST_CYC + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  logic              stb_r;
  logic              bit_r;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              first;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] shift_nxt;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;

  logic st_resync;
  logic st_acq;
  logic st_hunt;
  logic st_data;
  logic hold_done;
  logic good_last;
  logic frame_last;
  logic in_rng;
  logic out_rng;
  logic tmo;
  logic sync_hit;
  logic byte_done;
  logic enter_rs;
  logic ovf_set;

  assign st_resync = state == RESYNC;
  assign st_acq    = state == ACQUIRE;
  assign st_hunt   = state == HUNT;
  assign st_data   = state == DATA;

  assign hold_done  = hold_cnt == HOLD_W'(RST_CYC - 1);
  assign good_last  = good_cnt == GOOD_W'(LOCK_CNT - 1);
  assign frame_last = byte_cnt == 8'(FRAME_LEN - 1);

  assign shift_nxt = {sr[BYTE_W-2:0], bit_r};
  assign enter_rs  = (state_nxt == RESYNC) && !st_resync;
  assign ovf_set   = byte_done && byte_valid && !byte_ready;

  cdr_gap_mon #(
    .TIMEOUT (TIMEOUT),
    .MIN_GAP (MIN_GAP),
    .MAX_GAP (MAX_GAP)
  ) u_gap (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (st_resync),
    .stb_r   (stb_r),
    .first   (first),
    .in_rng  (in_rng),
    .out_rng (out_rng),
    .tmo     (tmo)
  );

  always_comb begin
    state_nxt = state;
    sync_hit  = 1'b0;
    byte_done = 1'b0;
    unique case (1'b1)
      st_resync: begin
        if (hold_done) state_nxt = ACQUIRE;
      end
      st_acq: begin
        if (tmo) begin
          state_nxt = RESYNC;
        end else if (in_rng && good_last) begin
          state_nxt = HUNT;
        end
      end
      st_hunt: begin
        if (tmo || out_rng) begin
          state_nxt = RESYNC;
        end else if (stb_r && shift_nxt == SYNC_WORD) begin
          sync_hit  = 1'b1;
          state_nxt = DATA;
        end
      end
      st_data: begin
        if (tmo || out_rng) begin
          state_nxt = RESYNC;
        end else if (stb_r && bit_cnt == 3'd7) begin
          byte_done = 1'b1;
          if (frame_last) state_nxt = HUNT;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stb_r       <= 1'b0;
      bit_r       <= 1'b0;
      state       <= RESYNC;
      hold_cnt    <= '0;
      good_cnt    <= '0;
      first       <= 1'b1;
      sr          <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      cdr_rstn    <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      resync_cnt  <= '0;
    end else begin
      stb_r       <= rcv_clk;
      bit_r       <= rcv_data;
      state       <= state_nxt;
      cdr_rstn    <= state_nxt != RESYNC;
      locked      <= (state_nxt == HUNT) ||
                     (state_nxt == DATA);
      frame_start <= sync_hit;

      if (enter_rs && resync_cnt != 8'hFF) begin
        resync_cnt <= resync_cnt + 8'd1;
      end

      if (st_resync && !hold_done) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end

      // The first strobe after resync only marks
      // the start of the first interval.
      if (st_resync) begin
        first <= 1'b1;
      end else if (stb_r) begin
        first <= 1'b0;
      end

      if (!st_acq) begin
        good_cnt <= '0;
      end else if (in_rng) begin
        good_cnt <= good_cnt + GOOD_W'(1);
      end else if (out_rng) begin
        good_cnt <= '0;
      end

      if (enter_rs) begin
        sr       <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (stb_r && (st_hunt || st_data)) begin
        sr <= shift_nxt;
        if (sync_hit) begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end else if (st_data) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (frame_last) sr <= '0;
          end
        end
      end
    end
  end

  // Output holding register: a held byte is never
  // overwritten; later bytes are dropped instead.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (byte_done && !ovf_set) begin
        byte_data  <= shift_nxt;
        byte_valid <= 1'b1;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdr_link_ctrl.sv
// Directed self-checking bench for cdr_link_ctrl.
// Drives 4-cycle strobes, frames, loss and overflow cases.
module tb_cdr_link_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rcv_clk = 1'b0;
  logic       rcv_data = 1'b0;
  logic       byte_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       cdr_rstn;
  logic       locked;
  logic       frame_start;
  logic       byte_valid;
  logic       overflow;
  logic [7:0] byte_data;
  logic [7:0] resync_cnt;

  int n_chk = 0;
  int n_err = 0;
  int fs_cnt = 0;
  logic [7:0] got_q[$];

  cdr_link_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .rcv_clk     (rcv_clk),
    .rcv_data    (rcv_data),
    .cdr_rstn    (cdr_rstn),
    .locked      (locked),
    .frame_start (frame_start),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow),
    .resync_cnt  (resync_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && frame_start) fs_cnt++;
    if (rstn && byte_valid && byte_ready) begin
      got_q.push_back(byte_data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_g(input logic b, input int n);
    rcv_clk  = 1'b1;
    rcv_data = b;
    step();
    rcv_clk = 1'b0;
    repeat (n - 1) step();
  endtask

  task automatic strobe(input logic b);
    strobe_g(b, 4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) strobe(v[i]);
  endtask

  task automatic send_hi7(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) strobe(v[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_cdr_rstn", cdr_rstn, 0);
    check("rst_locked", locked, 0);
    check("rst_fs", frame_start, 0);
    check("rst_bv", byte_valid, 0);
    check("rst_bd", byte_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rcnt", resync_cnt, 0);

    // Cycle 0 is the first cycle out of reset.
    rstn = 1'b1;
    repeat (7) step();
    check("cdr_rstn_c7", cdr_rstn, 0);
    step();
    check("cdr_rstn_c8", cdr_rstn, 1);

    repeat (16) strobe(1'b0);
    check("lock_s16", locked, 0);
    strobe(1'b0);
    check("lock_s17", locked, 1);

    // Frame A5 11 22 33 44 with consumer ready.
    byte_ready = 1'b1;
    send_hi7(8'hA5);
    rcv_clk = 1'b1;
    rcv_data = 1'b1;
    step();
    rcv_clk = 1'b0;
    check("fs_t1", frame_start, 0);
    step();
    check("fs_t2", frame_start, 1);
    step();
    check("fs_t3", frame_start, 0);
    step();

    send_hi7(8'h11);
    rcv_clk = 1'b1;
    rcv_data = 1'b1;
    step();
    rcv_clk = 1'b0;
    check("bv_t1", byte_valid, 0);
    step();
    check("bv_t2", byte_valid, 1);
    check("bd_t2", byte_data, 8'h11);
    step();
    check("bv_t3", byte_valid, 0);
    step();

    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("fs_count", fs_cnt, 1);
    check("byte_count", got_q.size(), 4);
    check("byte0", got_q[0], 8'h11);
    check("byte1", got_q[1], 8'h22);
    check("byte2", got_q[2], 8'h33);
    check("byte3", got_q[3], 8'h44);

    // Back in HUNT: a non-sync byte yields nothing.
    send_byte(8'h55);
    check("hunt_nobytes", got_q.size(), 4);
    check("hunt_locked", locked, 1);

    // Strobe loss in DATA.
    send_byte(8'hA5);
    check("tmo_state_data", fs_cnt, 2);
    repeat (398) step();
    check("tmo_pre_lock", locked, 1);
    step();
    check("tmo_lock", locked, 0);
    check("tmo_cdr_rstn", cdr_rstn, 0);
    check("tmo_rcnt", resync_cnt, 1);
    repeat (7) step();
    check("tmo_hold7", cdr_rstn, 0);
    step();
    check("tmo_hold8", cdr_rstn, 1);

    repeat (17) strobe(1'b0);
    check("relock1", locked, 1);

    // One 6-cycle interval in HUNT.
    strobe_g(1'b0, 6);
    strobe(1'b0);
    check("hunt6_lock", locked, 0);
    check("hunt6_rstn", cdr_rstn, 0);
    check("hunt6_rcnt", resync_cnt, 2);
    repeat (6) step();
    check("acq_rstn", cdr_rstn, 1);

    // Same interval in ACQUIRE after 10 good ones.
    repeat (10) strobe(1'b0);
    strobe_g(1'b0, 6);
    repeat (16) strobe(1'b0);
    check("acq6_lock15", locked, 0);
    check("acq6_rcnt", resync_cnt, 2);
    strobe(1'b0);
    check("acq6_lock16", locked, 1);

    // Consumer stalled through a frame.
    byte_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("ovf_bv", byte_valid, 1);
    check("ovf_bd", byte_data, 8'h11);
    check("ovf_set", overflow, 1);

    // Clear and accept inside one strobe interval.
    rcv_clk = 1'b1;
    rcv_data = 1'b0;
    ovf_clr = 1'b1;
    step();
    rcv_clk = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    check("ovf_keep_bd", byte_data, 8'h11);
    check("ovf_keep_bv", byte_valid, 1);
    byte_ready = 1'b1;
    step();
    byte_ready = 1'b0;
    check("ovf_acc_bv", byte_valid, 0);
    check("ovf_acc_n", got_q.size(), 5);
    check("ovf_acc_bd", got_q[4], 8'h11);
    step();
    step();

    // Async reset mid-byte with a held byte.
    send_byte(8'hA5);
    send_byte(8'h11);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    check("pre_rst_bv", byte_valid, 1);
    check("pre_rst_lock", locked, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_bv", byte_valid, 0);
    check("arst_bd", byte_data, 0);
    check("arst_lock", locked, 0);
    check("arst_rstn", cdr_rstn, 0);
    check("arst_rcnt", resync_cnt, 0);
    check("arst_ovf", overflow, 0);
    check("arst_fs", frame_start, 0);
    step();
    rstn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
